i8243_expander: RTL and testbench

- Synchronous model of an 8243 I/O expander hung off the i8048 core's P2[3:0] and PROG pins. Adds four 4-bit ports, P4..P7, for the KLR design.
- Runs on the system clock. PROG and P2 are treated as asynchronous pin inputs: they are synchronized, then edge-detected.
- Decodes MOVD/ANLD/ORLD bus cycles. Drives P2[3:0] back to the core during MOVD A,Pp reads.

---
 rtl/i8243_expander.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i8243_expander.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i8243_expander.sv
`default_nettype none
// ============================================================================
//  Module   : i8243_expander
//  Purpose  : Synchronous 8243-style I/O expander for the i8048 core. Decodes
//             MOVD / ANLD / ORLD bus cycles carried on P2[3:0] + PROG and adds
//             four 4-bit ports P4..P7.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   1  system clock, all state updates on the rising edge
//    res     in   1  synchronous reset, active high
//    cs_n    in   1  chip select (active low), sampled at the PROG fall
//    prog    in   1  PROG strobe from the core (asynchronous pin)
//    p2_in   in   4  P2[3:0] pin values (asynchronous pins)
//    p2_out  out  4  read data returned on P2[3:0]
//    p2_oe   out  1  P2[3:0] output enable
//    px_in   in  16  expander port pins  {P7,P6,P5,P4}
//    px_out  out 16  expander output latches {P7,P6,P5,P4}
//    px_oe   out  4  per-port output enable, bit0=P4 .. bit3=P7
//  Build option
//    I8243_PROG_FILTER_EN : glitch filter on PROG (FILTER_LEN stable cycles),
//                           cs_n / p2_in delayed to match.
// ============================================================================
module i8243_expander #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic        cs_n,
    input  logic        prog,
    input  logic [3:0]  p2_in,
    output logic [3:0]  p2_out,
    output logic        p2_oe,
    input  logic [15:0] px_in,
    output logic [15:0] px_out,
    output logic [3:0]  px_oe
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WDATA = 2'd2;

    localparam logic [1:0] c_CMD_READ  = 2'b00;
    localparam logic [1:0] c_CMD_WRITE = 2'b01;
    localparam logic [1:0] c_CMD_OR    = 2'b10;
    localparam logic [1:0] c_CMD_AND   = 2'b11;

    // Width of the post-reset flush counter (large enough for either build).
    localparam int c_FLW = $clog2(SYNC_STAGES + FILTER_LEN + 4);

    // ------------------------------------------------------------------
    // Input synchronizers; all idle high after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_prog_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [3:0]             r_p2_sync [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (res) begin
            r_prog_sync <= '1;
            r_cs_sync   <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) r_p2_sync[i] <= 4'hF;
        end else begin
            r_prog_sync[0] <= prog;
            r_cs_sync[0]   <= cs_n;
            r_p2_sync[0]   <= p2_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_prog_sync[i] <= r_prog_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_p2_sync[i]   <= r_p2_sync[i-1];
            end
        end
    end

    logic       w_prog_s;
    logic       w_cs_s;
    logic [3:0] w_p2_s;
    assign w_prog_s = r_prog_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_p2_s   = r_p2_sync[SYNC_STAGES-1];

    // Levels seen by the bus-cycle decoder.
    logic       w_prog_lvl;
    logic       w_cs_lvl;
    logic [3:0] w_p2_lvl;

`ifdef I8243_PROG_FILTER_EN
    localparam int c_FCW     = $clog2(FILTER_LEN + 1);
    localparam int c_ARM_LAT = SYNC_STAGES + FILTER_LEN + 2;

    logic             r_prog_filt;
    logic [c_FCW-1:0] r_filt_cnt;
    logic             r_cs_dly [FILTER_LEN];
    logic [3:0]       r_p2_dly [FILTER_LEN];

    // The filtered level flips only after the synced level has disagreed
    // with it for FILTER_LEN consecutive cycles; shorter pulses vanish.
    // cs_n / p2 go through a matching delay so they stay aligned.
    always_ff @(posedge clk) begin
        if (res) begin
            r_prog_filt <= 1'b1;
            r_filt_cnt  <= '0;
            for (int i = 0; i < FILTER_LEN; i++) begin
                r_cs_dly[i] <= 1'b1;
                r_p2_dly[i] <= 4'hF;
            end
        end else begin
            if (w_prog_s != r_prog_filt) begin
                if (r_filt_cnt == c_FCW'(FILTER_LEN - 1)) begin
                    r_prog_filt <= w_prog_s;
                    r_filt_cnt  <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + c_FCW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
            r_cs_dly[0] <= w_cs_s;
            r_p2_dly[0] <= w_p2_s;
            for (int i = 1; i < FILTER_LEN; i++) begin
                r_cs_dly[i] <= r_cs_dly[i-1];
                r_p2_dly[i] <= r_p2_dly[i-1];
            end
        end
    end

    assign w_prog_lvl = r_prog_filt;
    assign w_cs_lvl   = r_cs_dly[FILTER_LEN-1];
    assign w_p2_lvl   = r_p2_dly[FILTER_LEN-1];
`else
    localparam int c_ARM_LAT = SYNC_STAGES + 2;

    assign w_prog_lvl = w_prog_s;
    assign w_cs_lvl   = w_cs_s;
    assign w_p2_lvl   = w_p2_s;
`endif

    // ------------------------------------------------------------------
    // Edge detection. The synchronizer is preset high by reset, so a PROG
    // pin held low through reset would otherwise look like a fresh fall.
    // Falls are only honoured once the pipeline holds real samples and a
    // genuine high level has been seen; this drops the orphan rise that
    // belongs to a cycle cut short by reset.
    // ------------------------------------------------------------------
    logic             r_prog_prev;
    logic [c_FLW-1:0] r_flush;
    logic             r_armed;
    logic             w_fall;
    logic             w_rise;

    always_ff @(posedge clk) begin
        if (res) begin
            r_prog_prev <= 1'b1;
            r_flush     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_prog_prev <= w_prog_lvl;
            if (r_flush != c_FLW'(c_ARM_LAT)) begin
                r_flush <= r_flush + c_FLW'(1);
            end else if (w_prog_lvl) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall = r_armed & r_prog_prev & ~w_prog_lvl;
    assign w_rise = ~r_prog_prev & w_prog_lvl;

    // ------------------------------------------------------------------
    // Bus-cycle FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_cmd;
    logic [1:0] r_port;

    always_ff @(posedge clk) begin
        if (res) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fall && !w_cs_lvl) begin
                    if (w_p2_lvl[3:2] == c_CMD_READ) w_state_next = c_ST_READ;
                    else                             w_state_next = c_ST_WDATA;
                end
            end
            c_ST_READ:  if (w_rise) w_state_next = c_ST_IDLE;
            c_ST_WDATA: if (w_rise) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // New nibble for the addressed latch; OR/AND act on the latch, never
    // on the pins.
    logic [3:0] w_cur_nib;
    logic [3:0] w_wr_nib;
    assign w_cur_nib = px_out[{r_port, 2'b00} +: 4];

    always_comb begin
        w_wr_nib = w_cur_nib;
        case (r_cmd)
            c_CMD_WRITE: w_wr_nib = w_p2_lvl;
            c_CMD_OR:    w_wr_nib = w_cur_nib | w_p2_lvl;
            c_CMD_AND:   w_wr_nib = w_cur_nib & w_p2_lvl;
            default:     w_wr_nib = w_cur_nib;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (res) begin
            r_cmd  <= c_CMD_READ;
            r_port <= 2'd0;
            p2_out <= 4'h0;
            p2_oe  <= 1'b0;
            px_out <= 16'h0000;
            px_oe  <= 4'h0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall && !w_cs_lvl) begin
                        r_cmd  <= w_p2_lvl[3:2];
                        r_port <= w_p2_lvl[1:0];
                        if (w_p2_lvl[3:2] == c_CMD_READ) begin
                            // Addressed port turns into an input and the
                            // P2 driver starts on the same edge.
                            px_oe[w_p2_lvl[1:0]] <= 1'b0;
                            p2_oe                <= 1'b1;
                            p2_out               <= px_in[{w_p2_lvl[1:0], 2'b00} +: 4];
                        end
                    end
                end
                c_ST_READ: begin
                    if (w_rise) begin
                        p2_oe <= 1'b0;          // p2_out keeps its last value
                    end else begin
                        p2_oe  <= 1'b1;
                        p2_out <= px_in[{r_port, 2'b00} +: 4];
                    end
                end
                c_ST_WDATA: begin
                    if (w_rise) begin
                        px_out[{r_port, 2'b00} +: 4] <= w_wr_nib;
                        px_oe[r_port]                <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i8243_expander.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i8243_expander
//  Purpose  : Self-checking bench for i8243_expander. Directed bus cycles
//             followed by random MOVD/ORLD/ANLD traffic, compared against a
//             nibble-array model of the four expander ports.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i8243_expander;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;
`ifdef I8243_PROG_FILTER_EN
    localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif
    localparam int HOLD = LAT + 3;

    logic        clk = 1'b0;
    logic        res;
    logic        cs_n;
    logic        prog;
    logic [3:0]  p2_in;
    logic [3:0]  p2_out;
    logic        p2_oe;
    logic [15:0] px_in;
    logic [15:0] px_out;
    logic [3:0]  px_oe;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one nibble and one enable per port, plus the last
    // value returned on P2.
    logic [3:0] m_out [4];
    logic       m_oe  [4];
    logic [3:0] m_p2;

    always #5 clk = ~clk;

    i8243_expander #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_dut (
        .clk    (clk),
        .res    (res),
        .cs_n   (cs_n),
        .prog   (prog),
        .p2_in  (p2_in),
        .p2_out (p2_out),
        .p2_oe  (p2_oe),
        .px_in  (px_in),
        .px_out (px_out),
        .px_oe  (px_oe)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_out_vec();
        return {m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    function automatic logic [15:0] m_oe_vec();
        return {12'h000, m_oe[3], m_oe[2], m_oe[1], m_oe[0]};
    endfunction

    task automatic check_model(input string tag);
        check({tag, "/px_out"}, px_out, m_out_vec());
        check({tag, "/px_oe"}, {12'h000, px_oe}, m_oe_vec());
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = 4'h0;
            m_oe[i]  = 1'b0;
        end
        m_p2 = 4'h0;
    endtask

    task automatic model_write(input logic [1:0] cmd, input logic [1:0] port, input logic [3:0] d);
        case (cmd)
            2'b01:   m_out[port] = d;
            2'b10:   m_out[port] = m_out[port] | d;
            2'b11:   m_out[port] = m_out[port] & d;
            default: m_out[port] = m_out[port];
        endcase
        m_oe[port] = 1'b1;
    endtask

    // Write-type cycle: address at the fall, data before the rise. Checks the
    // latches one clock before and exactly at the expected update.
    task automatic bus_write(input string tag, input logic cs, input logic [1:0] cmd,
                             input logic [1:0] port, input logic [3:0] d);
        cs_n  = cs;
        p2_in = {cmd, port};
        prog  = 1'b0;
        tick(HOLD);
        check({tag, "/no_p2oe"}, {15'h0, p2_oe}, 16'h0);
        p2_in = d;
        tick(2);
        prog = 1'b1;
        tick(LAT - 1);
        check_model({tag, "/pre"});
        tick(1);
        if (!cs) model_write(cmd, port, d);
        check_model({tag, "/post"});
        cs_n = 1'b1;
        tick(2);
    endtask

    // Read cycle: pins sampled during the low phase, then changed to show
    // live tracking; P2 released after the rise with data held.
    task automatic bus_read(input string tag, input logic cs, input logic [1:0] port,
                            input logic [15:0] pins, input logic [15:0] pins2);
        logic [3:0] nib;
        px_in = pins;
        cs_n  = cs;
        p2_in = {2'b00, port};
        prog  = 1'b0;
        tick(LAT - 1);
        check({tag, "/oe_pre"}, {15'h0, p2_oe}, 16'h0);
        tick(1);
        if (!cs) begin
            m_oe[port] = 1'b0;
            nib  = pins[port*4 +: 4];
            m_p2 = nib;
        end
        check({tag, "/oe_low"}, {15'h0, p2_oe}, {15'h0, ~cs});
        check({tag, "/data_low"}, {12'h0, p2_out}, {12'h0, m_p2});
        check_model({tag, "/low"});
        px_in = pins2;
        tick(1);
        if (!cs) m_p2 = pins2[port*4 +: 4];
        check({tag, "/data_track"}, {12'h0, p2_out}, {12'h0, m_p2});
        tick(HOLD);
        prog = 1'b1;
        tick(LAT);
        check({tag, "/oe_rise"}, {15'h0, p2_oe}, 16'h0);
        check({tag, "/data_hold"}, {12'h0, p2_out}, {12'h0, m_p2});
        check_model({tag, "/end"});
        cs_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res   = 1'b1;
        cs_n  = 1'b1;
        prog  = 1'b1;
        p2_in = 4'hF;
        px_in = 16'h0000;
        model_reset();
        tick(3);
        res = 1'b0;
        tick(20);

        // Reset state
        check("reset/px_out", px_out, 16'h0000);
        check("reset/px_oe",  {12'h0, px_oe}, 16'h0000);
        check("reset/p2",     {11'h0, p2_oe, p2_out}, 16'h0000);

        // Write P5 = 1010, then ORLD 0101, then ANLD 0011
        bus_write("wr_p5",  1'b0, 2'b01, 2'd1, 4'hA);
        bus_write("or_p5",  1'b0, 2'b10, 2'd1, 4'h5);
        check("or_p5/val", px_out, 16'h00F0);
        bus_write("and_p5", 1'b0, 2'b11, 2'd1, 4'h3);
        check("and_p5/val", px_out, 16'h0030);
        check("and_p5/oe", {12'h0, px_oe}, 16'h0002);

        // Read P7 after driving it: oe drops, pins tracked
        bus_write("wr_p7", 1'b0, 2'b01, 2'd3, 4'hC);
        bus_read("rd_p7", 1'b0, 2'd3, 16'h9000, 16'h6000);

        // Deselected write to P4
        bus_write("desel", 1'b1, 2'b01, 2'd0, 4'hF);

        // OR/AND on a port in input mode uses the latch, not the pins
        bus_write("or_p7_in", 1'b0, 2'b10, 2'd3, 4'h1);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            logic        cs;
            logic [1:0]  port;
            logic [15:0] pa;
            logic [15:0] pb;
            cs   = ($urandom_range(0, 5) == 0);
            port = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                pa = 16'($urandom);
                pb = 16'($urandom);
                bus_read($sformatf("rnd%0d_rd", t), cs, port, pa, pb);
            end else begin
                bus_write($sformatf("rnd%0d_wr", t), cs, 2'($urandom_range(1, 3)), port,
                          4'($urandom));
            end
        end

`ifdef I8243_PROG_FILTER_EN
        // Short PROG glitch is discarded; a longer pulse is a real cycle
        cs_n  = 1'b0;
        p2_in = 4'b0100;
        prog  = 1'b0;
        tick(2);
        prog = 1'b1;
        tick(HOLD + 4);
        check_model("glitch");
        check("glitch/p2oe", {15'h0, p2_oe}, 16'h0);
        prog = 1'b0;
        tick(4);
        prog = 1'b1;
        tick(HOLD + 4);
        model_write(2'b01, 2'd0, 4'b0100);
        check_model("pulse4");
        cs_n = 1'b1;
        tick(2);
`endif

        // Reset in the middle of a write cycle
        bus_write("pre_rst", 1'b0, 2'b01, 2'd2, 4'h7);
        cs_n  = 1'b0;
        p2_in = {2'b01, 2'd1};
        prog  = 1'b0;
        tick(HOLD);
        p2_in = 4'hA;
        tick(1);
        res = 1'b1;
        tick(2);
        model_reset();
        check_model("rst_mid");
        check("rst_mid/p2oe", {15'h0, p2_oe}, 16'h0);
        res = 1'b0;
        tick(HOLD);
        prog = 1'b1;
        tick(HOLD + 4);
        check_model("rst_orphan_rise");
        cs_n = 1'b1;
        tick(2);

        // Normal operation resumes after reset
        bus_write("post_rst", 1'b0, 2'b01, 2'd0, 4'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
